// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divider: FSM encodings and sizing helpers.
package hilo_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/hilo_div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not borrow.
module div_step
    import hilo_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so a non-negative
    // difference fits in WIDTH bits and bit WIDTH is a pure borrow flag.
    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_q       = ~w_diff[WIDTH];
    assign o_rem     = o_q ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_div.sv
// Iterative restoring divider feeding the HI/LO register pair (hi = remainder, lo = quotient).
// Define HILO_DIV_SIGNED_EN to add signed (DIV) support; otherwise every division is unsigned.
module hilo_div
    import hilo_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_whilo;

    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_hi_final;
    logic [WIDTH-1:0] w_lo_final;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_accept;

    assign w_accept = (r_state == DIV_IDLE) && start_i && !annul_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dq[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_q       (w_q_bit)
    );

    // r_dq starts as the dividend magnitude and fills with quotient bits from the LSB.
    assign w_quo_final = (r_dq << 1) | WIDTH'(w_q_bit);

`ifdef HILO_DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_dvd_neg;
    logic w_dvs_neg;

    assign w_dvd_neg  = signed_i & dividend_i[WIDTH-1];
    assign w_dvs_neg  = signed_i & divisor_i[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend_i : dividend_i;
    assign w_dvs_mag  = w_dvs_neg ? -divisor_i  : divisor_i;
    assign w_lo_final = r_neg_q ? -w_quo_final : w_quo_final;
    assign w_hi_final = r_neg_r ? -w_rem_next  : w_rem_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = signed_i;
    assign w_dvd_mag       = dividend_i;
    assign w_dvs_mag       = divisor_i;
    assign w_lo_final      = w_quo_final;
    assign w_hi_final      = w_rem_next;
`endif

    // NOTE: every state register uses <= so all of them update from the same pre-edge values.
    // NOTE: reset_n sits in the sensitivity list, making the reset asynchronous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= DIV_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_dq      <= '0;
            r_divisor <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_whilo   <= 1'b0;
        end else if (annul_i) begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
            r_whilo <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start_i) begin
                        r_busy    <= 1'b1;
                        r_count   <= '0;
                        r_rem     <= '0;
                        r_divisor <= w_dvs_mag;
                        if (divisor_i == '0) begin
                            r_state <= DIV_BYZERO;
                            r_dq    <= dividend_i;
                        end else begin
                            r_state <= DIV_ON;
                            r_dq    <= w_dvd_mag;
                        end
                    end
                end
                DIV_BYZERO: begin
                    // Raw dividend was kept in r_dq, so hi reports it unmodified in either build.
                    r_state <= DIV_END;
                    r_busy  <= 1'b0;
                    r_whilo <= 1'b1;
                    r_hi    <= r_dq;
                    r_lo    <= '1;
                end
                DIV_ON: begin
                    r_rem   <= w_rem_next;
                    r_dq    <= w_quo_final;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_CNT) begin
                        r_state <= DIV_END;
                        r_busy  <= 1'b0;
                        r_whilo <= 1'b1;
                        r_hi    <= w_hi_final;
                        r_lo    <= w_lo_final;
                    end
                end
                DIV_END: begin
                    r_state <= DIV_IDLE;
                    r_whilo <= 1'b0;
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_busy  <= 1'b0;
                    r_whilo <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign whilo_o = r_whilo;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: tb/tb_hilo_div.sv
// Scoreboard bench for hilo_div: expected HI/LO pushed at request time, popped on each whilo_o strobe.
// Signed expectations follow HILO_DIV_SIGNED_EN when the bench is built with it.
module tb_hilo_div;

    localparam int W = 32;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b1;
    logic         start_i    = 1'b0;
    logic         signed_i   = 1'b0;
    logic         annul_i    = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i  = '0;
    logic         busy_o;
    logic         whilo_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    always #5 clk = ~clk;

    hilo_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .annul_i    (annul_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           n_checks  = 0;
    int           n_fail    = 0;
    int           n_strobes = 0;
    logic [W-1:0] last_hi   = '0;
    logic [W-1:0] last_lo   = '0;

    // Strobe counter samples the pre-edge value, so it never races the negedge checks.
    always @(posedge clk) if (whilo_o === 1'b1) n_strobes++;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        logic signed [W-1:0] da, db;
        if (b == '0) begin
            e.hi = a;
            e.lo = '1;
            return e;
        end
`ifdef HILO_DIV_SIGNED_EN
        if (s) begin
            da = a;
            db = b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.hi = '0;
                e.lo = 32'h8000_0000;
            end else begin
                e.lo = da / db;
                e.hi = da % db;
            end
            return e;
        end
`else
        da = '0;
        db = '0;
        if (s) e.hi = '0;
`endif
        e.hi = a % b;
        e.lo = a / b;
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_result(input string name, input int lat);
        int   j        = 0;
        int   busy_cnt = 0;
        logic held     = 1'b1;
        exp_t e;
        while (whilo_o !== 1'b1 && j <= 3 * W) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (hi_o !== last_hi || lo_o !== last_lo) held = 1'b0;
            @(negedge clk);
            j++;
        end
        n_checks++;
        if (j !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, j, lat);
        end
        n_checks++;
        if (busy_cnt !== lat) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cnt, lat);
        end
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hi/lo changed before strobe", name);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (hi_o !== e.hi) begin
                n_fail++;
                $display("FAIL %s hi_o: got %h, expected %h", name, hi_o, e.hi);
            end
            n_checks++;
            if (lo_o !== e.lo) begin
                n_fail++;
                $display("FAIL %s lo_o: got %h, expected %h", name, lo_o, e.lo);
            end
            last_hi = e.hi;
            last_lo = e.lo;
        end
        @(negedge clk);
        n_checks++;
        if (whilo_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after strobe: whilo=%b busy=%b, expected 0 0", name, whilo_o, busy_o);
        end
    endtask

    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        sb.push_back(model(a, b, s));
        start_op(a, b, s);
        wait_result(name, (b == '0) ? 1 : W);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, whilo_o, hi_o, lo_o} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: busy=%b whilo=%b hi=%h lo=%h, expected all 0",
                     busy_o, whilo_o, hi_o, lo_o);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned();
        run_div("udiv_100_7", 32'd100, 32'd7, 1'b0);
        run_div("udiv_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("udiv_5_7", 32'd5, 32'd7, 1'b0);
        run_div("udiv_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_div("udiv_0_5", 32'd0, 32'd5, 1'b0);
    endtask

    task automatic test_signed();
        run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_div("sdiv_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
        run_div("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_div_by_zero();
        run_div("div0_unsigned", 32'h0000_1234, 32'd0, 1'b0);
        run_div("div0_signed", 32'h8000_0000, 32'd0, 1'b1);
    endtask

    task automatic test_annul();
        int s0;
        s0 = n_strobes;
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL annul idle: busy=%b, expected 0", busy_o);
        end
        // Annul must also win over a simultaneous start.
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        annul_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL annul over start: busy=%b, expected 0", busy_o);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (n_strobes !== s0) begin
            n_fail++;
            $display("FAIL annul strobe count: got %0d, expected %0d", n_strobes, s0);
        end
        n_checks++;
        if (hi_o !== last_hi || lo_o !== last_lo) begin
            n_fail++;
            $display("FAIL annul hold: hi=%h lo=%h, expected %h %h", hi_o, lo_o, last_hi, last_lo);
        end
        run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0);
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = n_strobes;
        start_op(32'd100, 32'd7, 1'b0);
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, whilo_o, hi_o, lo_o} !== '0) begin
            n_fail++;
            $display("FAIL reset mid-op: busy=%b whilo=%b hi=%h lo=%h, expected all 0",
                     busy_o, whilo_o, hi_o, lo_o);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_hi = '0;
        last_lo = '0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (n_strobes !== s0) begin
            n_fail++;
            $display("FAIL reset mid-op strobe count: got %0d, expected %0d", n_strobes, s0);
        end
        run_div("after_reset_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   s0;
        int   accept_j   = -1;
        int   n_seen     = 0;
        int   strobe_j[2] = '{-1, -1};
        exp_t e;
        s0 = n_strobes;
        sb.push_back(model(32'd100, 32'd7, 1'b0));
        sb.push_back(model(32'd1000, 32'd33, 1'b0));
        @(negedge clk);
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend_i = 32'd1000;
        divisor_i  = 32'd33;
        for (int j = 0; j <= 2 * W + 4; j++) begin
            if (whilo_o === 1'b1) begin
                if (n_seen < 2) strobe_j[n_seen] = j;
                n_seen++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (hi_o !== e.hi || lo_o !== e.lo) begin
                        n_fail++;
                        $display("FAIL b2b result %0d: got hi=%h lo=%h, expected %h %h",
                                 n_seen, hi_o, lo_o, e.hi, e.lo);
                    end
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end
            if (start_i && n_seen >= 1 && busy_o === 1'b1) begin
                start_i  = 1'b0;
                accept_j = j;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        n_checks++;
        if (accept_j !== W + 2) begin
            n_fail++;
            $display("FAIL b2b second accept: got cycle %0d, expected %0d", accept_j, W + 2);
        end
        n_checks++;
        if (strobe_j[0] !== W || strobe_j[1] !== 2 * W + 2) begin
            n_fail++;
            $display("FAIL b2b strobe cycles: got %0d %0d, expected %0d %0d",
                     strobe_j[0], strobe_j[1], W, 2 * W + 2);
        end
        n_checks++;
        if (n_strobes - s0 !== 2 || n_seen !== 2) begin
            n_fail++;
            $display("FAIL b2b strobe count: got %0d, expected 2", n_strobes - s0);
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_div.md
# hilo_div

Iterative restoring divider that is the write-side producer for the HI/LO register pair. It accepts two 32-bit operands from the execute stage, runs one quotient bit per clock, and delivers remainder on `hi_o`, quotient on `lo_o` and a one-cycle `whilo_o` write strobe. These outputs connect directly to the HI/LO register's `hi_i`/`lo_i`/`whilo` inputs. `busy_o` stalls the pipeline while a division is in flight.

## Interface
- `WIDTH`, default 32: operand/result width.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request a division; sampled only in IDLE.
- `signed_i` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `annul_i` in 1: pipeline flush; abandons any operation.
- `dividend_i` in WIDTH: dividend; sampled with `start_i`.
- `divisor_i` in WIDTH: divisor; sampled with `start_i`.
- `busy_o` out 1: high in BYZERO and ON.
- `whilo_o` out 1: one-cycle write strobe; high exactly in END.
- `hi_o` out WIDTH: remainder.
- `lo_o` out WIDTH: quotient.

## Operation
- States: IDLE, BYZERO, ON, END. All outputs reset to 0, and the state resets to IDLE.
- IDLE:
  - `start_i`=1, `annul_i`=0 and divisor≠0: capture operands and go to ON with count=0.
  - Divisor=0 under the same conditions: go to BYZERO.
  - Signed mode captures the absolute values and records `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
- ON:
  - Each cycle performs one restoring step: shift the partial remainder left 1 and bring in the next dividend MSB, then trial-subtract the divisor.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - At count = WIDTH-1, go to END and register the final hi/lo.
  - Sign fix-up: the quotient is negated if `neg_q`, the remainder is negated if `neg_r`.
- BYZERO: go to END with `hi_o` = dividend and `lo_o` = all ones. This applies regardless of `signed_i`.
- END: `whilo_o`=1 for this single cycle. Unconditionally return to IDLE. `start_i` in END is ignored.
- `hi_o`/`lo_o` hold their last values outside END; they only change on the edge entering END.
- `annul_i`=1 in any state: IDLE on the next edge, with no `whilo_o` and `hi_o`/`lo_o` unchanged. `annul_i` overrides `start_i` in the same cycle.
- Signed overflow (most-negative ÷ -1): quotient = most-negative, remainder = 0. This falls out of the unsigned-magnitude datapath without special casing.
- `start_i` asserted while busy is ignored. The requester must hold `start_i` until `busy_o` rises or `whilo_o` pulses.

## Timing
- `start_i` sampled at edge k with divisor≠0:
  - `busy_o` high from after edge k until edge k+WIDTH.
  - `whilo_o` high in the cycle after edge k+WIDTH (WIDTH+1 cycles from request to strobe).
  - Back to IDLE after edge k+WIDTH+1.
- Divide-by-zero: BYZERO after edge k, `whilo_o` high after edge k+1.
- Back-to-back: the earliest next accepted `start_i` is at edge k+WIDTH+2, the first IDLE cycle.
- Asynchronous reset mid-operation: immediately IDLE, all outputs 0, no strobe.
- No combinational path from any input to any output; all outputs are registered or state-decoded.

## Configuration
- `HILO_DIV_SIGNED_EN`:
  - Defined: signed support as above (abs-value capture, sign fix-up negators).
  - Undefined: `signed_i` is ignored, all divisions are unsigned, and the negators and sign flags are removed.
  - Divide-by-zero behaviour is identical in both builds.

## Structure
- Shared package `hilo_pkg`:
  - State encodings `DIV_IDLE`/`DIV_BYZERO`/`DIV_ON`/`DIV_END` (2-bit).
  - Default `WIDTH`=32.
  - Counter width = clog2(WIDTH).
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- `hilo_div` holds the FSM, counter, operand/quotient shift registers, sign logic and output registers.

## Test plan
- Unsigned: 100 ÷ 7 with `signed_i`=0 → `whilo_o` after edge k+32; `hi_o`=2, `lo_o`=14; `busy_o` high exactly 32 cycles.
- Signed: -7 ÷ 2 → `lo_o`=0xFFFFFFFD (-3), `hi_o`=0xFFFFFFFF (-1). 7 ÷ -2 → `lo_o`=-3, `hi_o`=1. Without `HILO_DIV_SIGNED_EN`, 0xFFFFFFF9 ÷ 2 → `lo_o`=0x7FFFFFFC, `hi_o`=1.
- Divide-by-zero: 0x1234 ÷ 0 → `whilo_o` after edge k+1; `hi_o`=0x1234, `lo_o`=0xFFFFFFFF. Overflow: 0x80000000 ÷ 0xFFFFFFFF signed → `lo_o`=0x80000000, `hi_o`=0.
- Annul: start 100÷7, pulse `annul_i` at cycle 10 → no `whilo_o`, `hi_o`/`lo_o` keep their previous result, IDLE next cycle. A new start of 9÷3 then completes normally with `lo_o`=3, `hi_o`=0.
- Reset mid-operation: assert `reset_n`=0 at cycle 15 → all outputs 0 immediately. After release, 0xFFFFFFFF ÷ 1 unsigned → `lo_o`=0xFFFFFFFF, `hi_o`=0.
- Busy handling: hold `start_i` high continuously with new operands → second division accepted only at edge k+34; no strobe is lost or duplicated.
